// File: rtl/windrec2pol.sv
// windrec2pol: rectangular-to-polar converter for the wind-speed vector.
// An iterative vectoring-mode CORDIC turns (speedX, speedY) in Q6.10 into a
// Q6.10 magnitude and a Q9.7 angle in degrees, one micro-rotation per clock.
module windrec2pol #(
    parameter int INPUTBITSIZE  = 16,
    parameter int OUTPUTBITSIZE = 16,
    parameter int NITER         = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic signed [INPUTBITSIZE-1:0]  speedX,
    input  logic signed [INPUTBITSIZE-1:0]  speedY,
    output logic                            busy,
    output logic signed [OUTPUTBITSIZE-1:0] mod,
    output logic signed [OUTPUTBITSIZE-1:0] angle
);

    // x/y carry 2 guard integer bits and 6 extra fractional bits (Q8.16).
    localparam int XW        = INPUTBITSIZE + 8;
    // z is Q9.16 degrees plus one headroom bit for transient overshoot.
    localparam int ZW        = 26;
    localparam int CW        = $clog2(NITER + 1);
    // x (16 fractional bits) times K (16 fractional bits) gives 32; keep 10.
    localparam int PW        = XW + 17;
    localparam int MOD_SHIFT = 22;
    // z keeps 16 fractional bits, angle keeps 7.
    localparam int ANG_SHIFT = 9;

    localparam logic signed [ZW-1:0] Z_180   = ZW'(180 * 65536);
    localparam logic signed [ZW-1:0] ANG_MAX = ZW'(180 * 128);
    localparam logic        [16:0]   K_GAIN  = 17'd39797;  // 0.607253 in Q1.16
    localparam logic        [PW-1:0] MOD_MAX = PW'((1 << (OUTPUTBITSIZE - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_POST
    } state_t;

    state_t                          state_q, state_d;
    logic signed [XW-1:0]            x_q, x_d;
    logic signed [XW-1:0]            y_q, y_d;
    logic signed [ZW-1:0]            z_q, z_d;
    logic        [CW-1:0]            iter_q, iter_d;
    logic                            zero_q, zero_d;
    logic signed [OUTPUTBITSIZE-1:0] mod_q, mod_d;
    logic signed [OUTPUTBITSIZE-1:0] angle_q, angle_d;

    logic signed [XW-1:0]            x_shr, y_shr;
    logic signed [ZW-1:0]            atan_i;
    logic        [PW-1:0]            prod, prod_rnd, mod_full;
    logic signed [ZW-1:0]            z_rnd, z_shr;

    // atan(2^-i) in Q9.16 degrees.
    // NOTE: the table is a constant function, not a RAM, so there is no storage to reset.
    function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
        case (int'(idx))
            0:       return ZW'(2949120);
            1:       return ZW'(1740967);
            2:       return ZW'(919879);
            3:       return ZW'(466945);
            4:       return ZW'(234379);
            5:       return ZW'(117304);
            6:       return ZW'(58666);
            7:       return ZW'(29335);
            8:       return ZW'(14668);
            9:       return ZW'(7334);
            10:      return ZW'(3667);
            11:      return ZW'(1833);
            12:      return ZW'(917);
            13:      return ZW'(458);
            14:      return ZW'(229);
            15:      return ZW'(115);
            default: return '0;
        endcase
    endfunction

    // State register: one conversion walks IDLE -> PREP -> ITER x NITER -> POST.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (iter_q == CW'(NITER - 1)) state_d = S_POST;
            S_POST:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: busy is high only while idle with a valid result.
    always_comb begin
        busy = (state_q == S_IDLE);
    end

    // Final scaling: remove the CORDIC gain from x and round z to Q9.7.
    always_comb begin
        prod     = PW'($unsigned(x_q)) * PW'(K_GAIN);
        prod_rnd = prod + (PW'(1) << (MOD_SHIFT - 1));
        mod_full = prod_rnd >> MOD_SHIFT;
        z_rnd    = z_q + (ZW'(1) <<< (ANG_SHIFT - 1));
        z_shr    = z_rnd >>> ANG_SHIFT;
    end

    // Datapath: latch, pre-rotate, micro-rotate, then produce the result.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        mod_d   = mod_q;
        angle_d = angle_q;
        x_shr   = x_q >>> iter_q;
        y_shr   = y_q >>> iter_q;
        atan_i  = atan_lut(iter_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d    = {{2{speedX[INPUTBITSIZE-1]}}, speedX, 6'b0};
                    y_d    = {{2{speedY[INPUTBITSIZE-1]}}, speedY, 6'b0};
                    z_d    = '0;
                    iter_d = '0;
                    // atan2(0,0) is undefined; the accumulator would drift, so flag it.
                    zero_d = (speedX == '0) && (speedY == '0);
                end
            end
            S_PREP: begin
                // Fold the left half-plane onto the right one and seed +-180 deg.
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[XW-1] ? -Z_180 : Z_180;
                end else begin
                    z_d = '0;
                end
            end
            S_ITER: begin
                // Rotate towards y = 0; y = 0 counts as positive.
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_shr;
                    y_d = y_q - x_shr;
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - y_shr;
                    y_d = y_q + x_shr;
                    z_d = z_q - atan_i;
                end
                iter_d = iter_q + CW'(1);
            end
            S_POST: begin
                mod_d = (mod_full > MOD_MAX) ? MOD_MAX[OUTPUTBITSIZE-1:0]
                                             : mod_full[OUTPUTBITSIZE-1:0];
                if (zero_q) begin
                    angle_d = '0;
                end else if (z_shr > ANG_MAX) begin
                    angle_d = ANG_MAX[OUTPUTBITSIZE-1:0];
                end else if (z_shr < -ANG_MAX) begin
                    angle_d = OUTPUTBITSIZE'(-ANG_MAX);
                end else begin
                    angle_d = z_shr[OUTPUTBITSIZE-1:0];
                end
            end
            default: begin
                x_d = x_q;
            end
        endcase
    end

    // Datapath and result registers; reset clears everything and aborts a conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
            mod_q   <= '0;
            angle_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
            mod_q   <= mod_d;
            angle_q <= angle_d;
        end
    end

    assign mod   = mod_q;
    assign angle = angle_q;

endmodule

// File: tb/tb_windrec2pol.sv
// Testbench for windrec2pol: directed vectors feed a scoreboard queue, and a
// monitor pops and compares whenever busy rises at the end of a conversion.
module tb_windrec2pol;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] speedX;
    logic signed [15:0] speedY;
    logic               busy;
    logic signed [15:0] mod;
    logic signed [15:0] angle;

    windrec2pol #(
        .INPUTBITSIZE (16),
        .OUTPUTBITSIZE(16),
        .NITER        (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .speedX(speedX),
        .speedY(speedY),
        .busy  (busy),
        .mod   (mod),
        .angle (angle)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    mod_e;
        int    ang_e;
        int    mod_tol;
        int    ang_tol;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act >= exp - tol && act <= exp + tol) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    // Monitor: a busy rise not caused by reset marks a finished conversion.
    logic busy_prev     = 1'b1;
    logic reset_at_edge = 1'b1;

    always @(posedge clock) reset_at_edge <= reset;

    always @(negedge clock) begin
        if (busy && !busy_prev && !reset_at_edge) begin
            if (sb_q.size() == 0) begin
                check("unexpected result", 1, 0, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, " mod"},   int'(mod),   mon_e.mod_e, mon_e.mod_tol);
                check({mon_e.name, " angle"}, int'(angle), mon_e.ang_e, mon_e.ang_tol);
            end
        end
        busy_prev = busy;
    end

    // Issue one conversion and check busy timing; results go through the scoreboard.
    task automatic convert(input string name, input logic signed [15:0] x, input logic signed [15:0] y,
                           input int mod_e, input int ang_e, input int mod_tol, input int ang_tol,
                           input bit b2b, input bit repulse);
        exp_t e;
        int   n;
        if (!b2b) begin
            @(posedge clock);
            #1;
        end
        speedX    = x;
        speedY    = y;
        start     = 1'b1;
        e.name    = name;
        e.mod_e   = mod_e;
        e.ang_e   = ang_e;
        e.mod_tol = mod_tol;
        e.ang_tol = ang_tol;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check({name, " busy low"}, int'(busy), 0, 0);
        n = 0;
        while (n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (busy) break;
            if (repulse && n == 2) begin
                speedX = 16'sh1234;
                speedY = -16'sh0800;
            end
            if (repulse && n == 5) start = 1'b1;
            if (repulse && n == 6) start = 1'b0;
        end
        check({name, " latency"}, n, 18, 0);
    endtask

    // Start a conversion and reset it five edges later.
    task automatic abort_test();
        @(posedge clock);
        #1;
        speedX = 16'sh0C00;
        speedY = 16'sh1000;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort busy",  int'(busy),  1, 0);
        check("abort mod",   int'(mod),   0, 0);
        check("abort angle", int'(angle), 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        speedX = '0;
        speedY = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset busy",  int'(busy),  1, 0);
        check("reset mod",   int'(mod),   0, 0);
        check("reset angle", int'(angle), 0, 0);

        //        name          X             Y            mod    angle  mtol atol b2b rep
        convert("q1 3,4",     16'sh0C00,  16'sh1000,   5120,   6801, 2, 6, 0, 0);
        convert("-1,0",      -16'sh0400,  16'sh0000,   1024,  23040, 2, 0, 0, 0);
        convert("0,-2",       16'sh0000, -16'sh0800,   2048, -11520, 2, 6, 0, 0);
        convert("sat 7fff",   16'sh7FFF,  16'sh7FFF,  32767,   5760, 0, 6, 0, 0);
        convert("zero",       16'sh0000,  16'sh0000,      0,      0, 0, 0, 0, 0);
        convert("-3,-4",     -16'sh0C00, -16'sh1000,   5120, -16239, 2, 6, 0, 0);
        convert("repulse",    16'sh1000, -16'sh0C00,   5120,  -4719, 2, 6, 0, 1);
        convert("-2,2",      -16'sh0800,  16'sh0800,   2896,  17280, 2, 6, 1, 0);
        convert("min,min",   -16'sh8000, -16'sh8000,  32767, -17280, 0, 6, 1, 0);
        convert("7fff,0",     16'sh7FFF,  16'sh0000,  32767,      0, 2, 6, 0, 0);
        abort_test();
        convert("post abort", 16'sh0400,  16'sh0000,   1024,      0, 2, 6, 0, 0);

        @(negedge clock);
        @(posedge clock);
        #1;
        check("scoreboard drained", sb_q.size(), 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
